// File: rtl/wb_mux_pkg.sv
// rtl/wb_mux_pkg.sv - shared state encoding and constants for the wishbone slave mux
package wb_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DONE = 2'd2
  } mux_state_t;

  localparam logic [31:0] ERR_DATA     = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_S0_BASE  = 32'h4100_0000;
  localparam logic [31:0] DEF_S0_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] DEF_S1_BASE  = 32'h4200_0000;
  localparam logic [31:0] DEF_S1_MASK  = 32'hFFFF_0000;
  localparam int unsigned DEF_TIMEOUT  = 16;

endpackage

// File: rtl/wb_slave_mux_if.sv
// rtl/wb_slave_mux_if.sv - master-side, two slave-side and error-report signals of the mux
interface wb_slave_mux_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic        s0_cyc_o;
  logic        s0_stb_o;
  logic        s0_we_o;
  logic [3:0]  s0_sel_o;
  logic [31:0] s0_adr_o;
  logic [31:0] s0_dat_o;
  logic        s0_ack_i;
  logic [31:0] s0_dat_i;

  logic        s1_cyc_o;
  logic        s1_stb_o;
  logic        s1_we_o;
  logic [3:0]  s1_sel_o;
  logic [31:0] s1_adr_o;
  logic [31:0] s1_dat_o;
  logic        s1_ack_i;
  logic [31:0] s1_dat_i;

  logic        err_o;
  logic [31:0] err_adr_o;
  logic        err_clr_i;

  // The mux itself: a slave on the master bus, a master toward s0/s1.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output s0_cyc_o, s0_stb_o, s0_we_o, s0_sel_o, s0_adr_o, s0_dat_o,
    input  s0_ack_i, s0_dat_i,
    output s1_cyc_o, s1_stb_o, s1_we_o, s1_sel_o, s1_adr_o, s1_dat_o,
    input  s1_ack_i, s1_dat_i,
    output err_o, err_adr_o,
    input  err_clr_i
  );

  // Environment around the mux: the bus master plus both slave devices.
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  s0_cyc_o, s0_stb_o, s0_we_o, s0_sel_o, s0_adr_o, s0_dat_o,
    output s0_ack_i, s0_dat_i,
    input  s1_cyc_o, s1_stb_o, s1_we_o, s1_sel_o, s1_adr_o, s1_dat_o,
    output s1_ack_i, s1_dat_i,
    input  err_o, err_adr_o,
    output err_clr_i
  );

endinterface

// File: rtl/wb_mux_timer.sv
// rtl/wb_mux_timer.sv - forward-phase watchdog, expired on the TIMEOUT-th enabled cycle
module wb_mux_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Saturates at LAST so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - one-master two-slave wishbone address decoder with timeout and error capture
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter logic [31:0] S0_BASE = DEF_S0_BASE,
  parameter logic [31:0] S0_MASK = DEF_S0_MASK,
  parameter logic [31:0] S1_BASE = DEF_S1_BASE,
  parameter logic [31:0] S1_MASK = DEF_S1_MASK,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_slave_mux_if.slave  bus
);

  mux_state_t  state;
  logic        sel_q;
  logic        s0_act;
  logic        s1_act;
  logic        ack_q;
  logic [31:0] dat_q;
  logic        err_q;
  logic [31:0] err_adr_q;

  logic        hit0;
  logic        hit1;
  logic        req;
  logic        sel_ack;
  logic [31:0] sel_dat;
  logic        expired;
  logic        err_set;

  assign hit0    = (bus.wbs_adr_i & S0_MASK) == S0_BASE;
  assign hit1    = (bus.wbs_adr_i & S1_MASK) == S1_BASE;
  assign req     = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
  assign sel_ack = sel_q ? bus.s1_ack_i : bus.s0_ack_i;
  assign sel_dat = sel_q ? bus.s1_dat_i : bus.s0_dat_i;

  // Faults are a decode miss in IDLE or a watchdog expiry with the cycle still held and no ack.
  assign err_set = ((state == ST_IDLE) && req && !hit0 && !hit1) ||
                   ((state == ST_FWD) && bus.wbs_cyc_i && !sel_ack && expired);

  wb_mux_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (state != ST_FWD),
    .enable  (state == ST_FWD),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      sel_q     <= 1'b0;
      s0_act    <= 1'b0;
      s1_act    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
    end else begin
      ack_q <= 1'b0;
      dat_q <= '0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (hit0 || hit1) begin
              sel_q  <= ~hit0;
              s0_act <= hit0;
              s1_act <= ~hit0;
              state  <= ST_FWD;
            end else begin
              ack_q <= 1'b1;
              dat_q <= ERR_DATA;
              state <= ST_DONE;
            end
          end
        end
        ST_FWD: begin
          // Abort has priority: a master that walked away gets no ack at all.
          if (!bus.wbs_cyc_i) begin
            s0_act <= 1'b0;
            s1_act <= 1'b0;
            state  <= ST_IDLE;
          end else if (sel_ack) begin
            s0_act <= 1'b0;
            s1_act <= 1'b0;
            ack_q  <= 1'b1;
            dat_q  <= bus.wbs_we_i ? 32'h0 : sel_dat;
            state  <= ST_DONE;
          end else if (expired) begin
            s0_act <= 1'b0;
            s1_act <= 1'b0;
            ack_q  <= 1'b1;
            dat_q  <= ERR_DATA;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          s0_act <= 1'b0;
          s1_act <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase

      if (err_set) begin
        err_q     <= 1'b1;
        err_adr_q <= bus.wbs_adr_i;
      end else if (bus.err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.err_o     = err_q;
  assign bus.err_adr_o = err_adr_q;

  assign bus.s0_cyc_o = s0_act;
  assign bus.s0_stb_o = s0_act;
  assign bus.s0_we_o  = bus.wbs_we_i;
  assign bus.s0_sel_o = bus.wbs_sel_i;
  assign bus.s0_adr_o = bus.wbs_adr_i;
  assign bus.s0_dat_o = bus.wbs_dat_i;

  assign bus.s1_cyc_o = s1_act;
  assign bus.s1_stb_o = s1_act;
  assign bus.s1_we_o  = bus.wbs_we_i;
  assign bus.s1_sel_o = bus.wbs_sel_i;
  assign bus.s1_adr_o = bus.wbs_adr_i;
  assign bus.s1_dat_o = bus.wbs_dat_i;

endmodule
